// File: rtl/flash_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_ctrl_pkg
// Brief    : Shared types and frame constants for the XIP flash read
//            controller (state encoding, read opcode, frame field widths).
// Revision : 1.0 - initial release
// ============================================================================
package flash_ctrl_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Serial NOR "read data" opcode.
  localparam logic [7:0] CMD_READ = 8'h03;

  // Frame layout: opcode, 24-bit address, 32 data bits, MSB first.
  localparam int FRAME_BITS = 64;
  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DATA_BITS  = 32;

  // The flash streams the lowest-addressed byte first; the core wants it in
  // the least significant byte of the word.
  function automatic logic [DATA_BITS-1:0] bswap32(input logic [DATA_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/flash_rr_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_rr_arb
// Brief    : Two-way round-robin arbiter. A lone requester always wins; on a
//            tie the port that was not granted last time wins.
// Revision : 1.0 - initial release
// ============================================================================
module flash_rr_arb (
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // One-hot grant, forced to zero whenever the controller cannot accept.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_xip_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : flash_xip_ctrl
// Brief    : SPI mode-0 master issuing 03h word reads to a serial NOR flash
//            on behalf of two round-robin arbitrated requesters (port 0 =
//            instruction fetch, port 1 = data load). Returns little-endian
//            32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module flash_xip_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter int DIV    = 2,  // sck half-period in clocks (1..255)
  parameter int CS_GAP = 2   // min clocks ss stays high between frames (1..255)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [47:0] req_addr,
  output logic [1:0]  req_ready,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_data,
  output logic        busy,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  localparam logic [7:0] DIV_LAST   = 8'(DIV - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(CS_GAP - 1);
  localparam logic [5:0] LAST_BIT   = 6'(FRAME_BITS - 1);
  localparam logic [5:0] DATA_START = 6'(CMD_BITS + ADDR_BITS);

  state_t                  state_q;
  logic                    port_q;        // port owning the current frame
  logic                    last_grant_q;  // port granted most recently
  logic [FRAME_BITS-1:0]   frame_q;       // outgoing bits, MSB is next out
  logic [DATA_BITS-1:0]    data_q;        // captured miso bits
  logic [5:0]              bit_q;         // index of the bit on the wire
  logic [7:0]              div_q;         // clocks spent in current sck phase
  logic [7:0]              gap_q;         // remaining ss-high clocks
  logic                    sck_q;
  logic                    ss_q;
  logic                    mosi_q;
  logic [1:0]              resp_valid_q;
  logic [DATA_BITS-1:0]    resp_data_q;

  logic [1:0]              grant;
  logic                    arb_en;
  logic                    accept;
  logic [ADDR_BITS-1:0]    sel_addr;

  // Requests are only granted while idle and out of reset.
  assign arb_en = (state_q == IDLE) && reset;

  flash_rr_arb u_arb (
    .req        (req_valid),
    .enable     (arb_en),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel_addr  = grant[1] ? req_addr[47:24] : req_addr[23:0];

  // Frame sequencer: accept, shift 64 bits with a DIV-clock half period,
  // present the response, then enforce the chip-select gap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;
      frame_q      <= '0;
      data_q       <= '0;
      bit_q        <= '0;
      div_q        <= '0;
      gap_q        <= '0;
      sck_q        <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      resp_valid_q <= 2'b00;
      resp_data_q  <= '0;
    end else begin
      // The gap timer free-runs down from the ss rising edge.
      if (gap_q != 8'd0) begin
        gap_q <= gap_q - 8'd1;
      end

      case (state_q)
        IDLE: begin
          if (accept) begin
            port_q       <= grant[1];
            last_grant_q <= grant[1];
            // Word reads only: the two low address bits are dropped.
            frame_q      <= {CMD_READ, sel_addr & 24'hFFFFFC, {DATA_BITS{1'b0}}};
            state_q      <= SHIFT;
          end
        end

        SHIFT: begin
          if (ss_q) begin
            // First cycle after accept: select the device, present bit 0.
            ss_q    <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= frame_q[FRAME_BITS-1];
            frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
            div_q   <= 8'd0;
            bit_q   <= 6'd0;
          end else if (div_q != DIV_LAST) begin
            div_q <= div_q + 8'd1;
          end else begin
            div_q <= 8'd0;
            if (!sck_q) begin
              // Rising sck: the flash has had a full low phase to settle miso.
              sck_q <= 1'b1;
              if (bit_q >= DATA_START) begin
                data_q <= {data_q[DATA_BITS-2:0], miso};
              end
            end else begin
              sck_q <= 1'b0;
              if (bit_q == LAST_BIT) begin
                ss_q         <= 1'b1;
                mosi_q       <= 1'b0;
                resp_valid_q <= port_q ? 2'b10 : 2'b01;
                resp_data_q  <= bswap32(data_q);
                gap_q        <= GAP_LOAD;
                state_q      <= RESP;
              end else begin
                // mosi only moves on the falling sck edge (mode 0).
                bit_q   <= bit_q + 6'd1;
                mosi_q  <= frame_q[FRAME_BITS-1];
                frame_q <= {frame_q[FRAME_BITS-2:0], 1'b0};
              end
            end
          end
        end

        RESP: begin
          // Only the owning port's ready completes the handshake.
          if (resp_ready[port_q]) begin
            resp_valid_q <= 2'b00;
            state_q      <= (gap_q <= 8'd1) ? IDLE : GAP;
          end
        end

        GAP: begin
          if (gap_q <= 8'd1) begin
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;
  assign busy       = (state_q != IDLE) || (|resp_valid_q);

endmodule
`default_nettype wire

// File: tb/tb_flash_xip_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_flash_xip_ctrl
// Brief    : Self-checking bench. Three controller instances (DIV = 1, 2, 3)
//            each talk to a behavioural serial NOR flash and run randomized
//            reads, arbitration, backpressure and mid-frame reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flash_xip_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Flash contents: a fixed word at 0x100, a hash everywhere else.
  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [23:0] h;
    case (a)
      24'h000100: return 8'h78;
      24'h000101: return 8'h56;
      24'h000102: return 8'h34;
      24'h000103: return 8'h12;
      default: begin
        h = (a ^ (a >> 7)) * 24'd40503;
        return h[15:8] ^ h[7:0];
      end
    endcase
  endfunction

  // Little-endian word at the word-aligned address.
  function automatic logic [31:0] exp_word(input logic [23:0] a);
    logic [23:0] b;
    b = {a[23:2], 2'b00};
    return {byte_at(b + 24'd3), byte_at(b + 24'd2), byte_at(b + 24'd1), byte_at(b)};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int D = g + 1;
    localparam int G = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

    logic        rst_n      = 1'b1;
    logic [1:0]  req_valid  = 2'b00;
    logic [47:0] req_addr   = '0;
    logic [1:0]  resp_ready = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic        busy;
    logic        sck;
    logic        ss;
    logic        mosi;
    logic        miso = 1'b0;
    bit          done = 1'b0;
    int          last_m = 1;

    flash_xip_ctrl #(.DIV(D), .CS_GAP(G)) u_dut (
      .clock      (clk),
      .reset      (rst_n),
      .req_valid  (req_valid),
      .req_addr   (req_addr),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .busy       (busy),
      .sck        (sck),
      .ss         (ss),
      .mosi       (mosi),
      .miso       (miso)
    );

    // ---------------- serial NOR flash model ----------------
    int          fbits = 0;
    logic [31:0] fshift = '0;
    logic [7:0]  fcmd = '0;
    logic [23:0] faddr = '0;
    int          data_mosi_err = 0;

    always @(posedge sck or posedge ss) begin
      if (ss) begin
        fbits = 0;
      end else begin
        if (fbits < 32) fshift = {fshift[30:0], mosi};
        else if (mosi) data_mosi_err++;
        fbits++;
        if (fbits == 32) begin
          fcmd  = fshift[31:24];
          faddr = fshift[23:0];
        end
      end
    end

    always @(negedge sck) begin : flash_out
      int j;
      logic [7:0] bv;
      if (!ss && fbits >= 32 && fbits < 64) begin
        j  = fbits - 32;
        bv = byte_at(faddr + 24'(j / 8));
        miso <= bv[7 - (j % 8)];
      end
    end

    // ---------------- pin-level protocol monitor ----------------
    logic pss = 1'b1, psck = 1'b0, pmosi = 1'b0;
    int   run = 0, runs = 0, lowcnt = 0, high_since = 0;
    bit   seen_frame = 1'b0;
    int   sck_err = 0, mosi_err = 0, gap_err = 0;
    int   last_runs = 0, last_low = 0;

    always @(negedge clk) begin
      if (!rst_n) begin
        pss = 1'b1; psck = 1'b0; pmosi = 1'b0;
        run = 0; runs = 0; lowcnt = 0; high_since = 0; seen_frame = 1'b0;
      end else begin
        if (!ss) begin
          if (pss) begin
            if (seen_frame && high_since < G) gap_err++;
            if (sck) sck_err++;
            run = 1; runs = 0; lowcnt = 1;
          end else begin
            lowcnt++;
            if (sck == psck) run++;
            else begin
              if (run != D) sck_err++;
              runs++;
              run = 1;
            end
            if (mosi != pmosi && !(psck && !sck)) mosi_err++;
          end
        end else begin
          if (!pss) begin
            if (run != D) sck_err++;
            runs++;
            last_runs  = runs;
            last_low   = lowcnt;
            seen_frame = 1'b1;
            high_since = 0;
            if (sck) sck_err++;
          end
          high_since++;
        end
        pss = ss; psck = sck; pmosi = mosi;
      end
    end

    // ---------------- stimulus helpers ----------------
    function automatic string tg(input string s);
      return $sformatf("div%0d_%s", D, s);
    endfunction

    task automatic wait_grant(output int gp, output bit ok);
      int n;
      n = 0; ok = 1'b0; gp = 0;
      while (!ok && n < 200) begin
        @(negedge clk);
        if (req_ready != 2'b00) begin
          ok = 1'b1;
          gp = req_ready[1] ? 1 : 0;
        end else n++;
      end
      if (!ok) chk(tg("grant_timeout"), 0, 1);
    endtask

    task automatic wait_resp(output int lat, output bit ok);
      lat = 0; ok = 1'b0;
      while (!ok && lat < 128 * D + 40) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        if (resp_valid != 2'b00) ok = 1'b1;
      end
      if (!ok) chk(tg("resp_timeout"), 0, 1);
    endtask

    task automatic do_read(input int p, input logic [23:0] a, input int hold);
      int gp, lat;
      bit ok, stable, rdy0;
      @(posedge clk); #1;
      req_addr[p*24 +: 24] = a;
      req_valid[p] = 1'b1;
      wait_grant(gp, ok);
      if (!ok) begin req_valid = 2'b00; return; end
      chk(tg("grant_single"), req_ready, 1 << p);
      @(posedge clk); #1;
      req_valid[p] = 1'b0;
      last_m = p;
      chk(tg("busy_after_accept"), busy, 1);
      wait_resp(lat, ok);
      if (!ok) return;
      chk(tg("latency"), lat, 128 * D + 1);
      chk(tg("resp_port"), resp_valid, 1 << p);
      chk(tg("resp_data"), resp_data, exp_word(a));
      chk(tg("frame_cmd"), fcmd, 8'h03);
      chk(tg("frame_addr"), faddr, {a[23:2], 2'b00});
      chk(tg("ss_low_clocks"), last_low, 128 * D);
      chk(tg("sck_phases"), last_runs, 128);
      chk(tg("sck_phase_err"), sck_err, 0);
      chk(tg("mosi_edge_err"), mosi_err, 0);
      chk(tg("mosi_data_err"), data_mosi_err, 0);
      chk(tg("cs_gap_err"), gap_err, 0);
      stable = 1'b1; rdy0 = 1'b1;
      for (int i = 0; i < hold; i++) begin
        resp_ready = 2'(1 << (1 - p));
        req_valid[1 - p] = 1'b1;
        @(negedge clk);
        if (resp_valid != 2'(1 << p) || resp_data != exp_word(a)) stable = 1'b0;
        if (req_ready != 2'b00) rdy0 = 1'b0;
      end
      if (hold > 0) begin
        chk(tg("hold_stable"), stable, 1);
        chk(tg("hold_no_ready"), rdy0, 1);
      end
      req_valid  = 2'b00;
      resp_ready = 2'(1 << p);
      @(posedge clk); #1;
      resp_ready = 2'b00;
      @(negedge clk);
      chk(tg("resp_cleared"), resp_valid, 0);
    endtask

    task automatic arb_test();
      logic [23:0] a [2];
      logic [23:0] acc;
      int gp, lat, expp;
      bit ok;
      a[0] = 24'($urandom());
      a[1] = 24'($urandom());
      @(posedge clk); #1;
      req_addr  = {a[1], a[0]};
      req_valid = 2'b11;
      for (int k = 0; k < 3; k++) begin
        wait_grant(gp, ok);
        if (!ok) break;
        expp = (last_m == 1) ? 0 : 1;
        chk(tg("rr_grant"), req_ready, 1 << expp);
        @(posedge clk); #1;
        last_m = expp;
        acc    = a[gp];
        a[gp]  = 24'($urandom());
        req_addr = {a[1], a[0]};
        wait_resp(lat, ok);
        if (!ok) break;
        chk(tg("rr_route"), resp_valid, 1 << gp);
        chk(tg("rr_data"), resp_data, exp_word(acc));
        resp_ready = 2'(1 << gp);
        @(posedge clk); #1;
        resp_ready = 2'b00;
      end
      req_valid = 2'b00;
      chk(tg("rr_gap_err"), gap_err, 0);
    endtask

    task automatic reset_mid();
      int n, gp;
      bit ok, quiet;
      n = 0; quiet = 1'b1;
      @(posedge clk); #1;
      req_addr[23:0] = 24'h000300;
      req_valid[0]   = 1'b1;
      wait_grant(gp, ok);
      @(posedge clk); #1;
      req_valid = 2'b00;
      while (fbits < 41 && n < 128 * D + 10) begin
        @(negedge clk);
        n++;
      end
      chk(tg("reached_bit40"), fbits >= 41, 1);
      #1 rst_n = 1'b0;
      #1;
      chk(tg("rst_ss"), ss, 1);
      chk(tg("rst_sck"), sck, 0);
      chk(tg("rst_mosi"), mosi, 0);
      chk(tg("rst_resp_valid"), resp_valid, 0);
      chk(tg("rst_busy"), busy, 0);
      chk(tg("rst_resp_data"), resp_data, 0);
      repeat (3) @(negedge clk);
      rst_n  = 1'b1;
      last_m = 1;
      repeat (128 * D + 20) begin
        @(negedge clk);
        if (resp_valid != 2'b00) quiet = 1'b0;
      end
      chk(tg("no_resp_after_abort"), quiet, 1);
      do_read(0, 24'h000200, 0);
    endtask

    initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk(tg("reset_req_ready"), req_ready, 0);
      chk(tg("reset_resp_valid"), resp_valid, 0);
      chk(tg("reset_resp_data"), resp_data, 0);
      chk(tg("reset_busy"), busy, 0);
      chk(tg("reset_sck"), sck, 0);
      chk(tg("reset_ss"), ss, 1);
      chk(tg("reset_mosi"), mosi, 0);
      rst_n = 1'b1;
      arb_test();
      do_read(0, 24'h000100, 0);
      do_read(1, 24'h000107, 0);
      do_read(0, 24'hFFFFFC, 0);
      do_read(1, 24'hFFFFFF, 2);
      do_read(int'($urandom_range(0, 1)), 24'($urandom()), 50);
      for (int k = 0; k < 5; k++) begin
        do_read(int'($urandom_range(0, 1)), 24'($urandom()), int'($urandom_range(0, 4)));
      end
      reset_mid();
      done = 1'b1;
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    chk("all_instances_done",
        {g_inst[2].done, g_inst[1].done, g_inst[0].done}, 3'b111);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
